// File: rtl/icache_line_fill.sv
// Icache miss fill engine: fetches a 4-beat burst from physical memory, assembles
// the beats into one cache line and commits line plus tag in a single cycle.
module icache_line_fill #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256,
  parameter int IDX_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      miss_req,
  input  logic [ADDR_W-1:0]         miss_addr,
  output logic                      busy,
  output logic                      fill_done,
  output logic                      pmem_read,
  output logic [ADDR_W-1:0]         pmem_address,
  input  logic [BEAT_W-1:0]         pmem_rdata,
  input  logic                      pmem_resp,
  output logic [LINE_W/8-1:0]       data_load,
  output logic [IDX_W-1:0]          data_windex,
  output logic [LINE_W-1:0]         data_datain,
  output logic                      tag_load,
  output logic [ADDR_W-IDX_W-5-1:0] tag_out
);

  localparam int OFF_W      = $clog2(LINE_W / 8);
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_CNT_W = $clog2(BEATS);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [BEAT_CNT_W-1:0]   r_beat;
  logic [LINE_W-1:0]       r_line;
  logic [ADDR_W-1:0]       w_line_addr;
  logic                    w_unused_offset;

  assign w_line_addr     = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unused_offset = ^miss_addr[OFF_W-1:0];
  assign data_datain     = r_line;

  // pmem_address doubles as the latched line address for the commit fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_line       <= '0;
      busy         <= 1'b0;
      fill_done    <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_address <= '0;
      data_load    <= '0;
      data_windex  <= '0;
      tag_load     <= 1'b0;
      tag_out      <= '0;
    end else begin
      data_load <= '0;
      tag_load  <= 1'b0;
      fill_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_req) begin
            pmem_address <= w_line_addr;
            pmem_read    <= 1'b1;
            busy         <= 1'b1;
            r_beat       <= '0;
            r_state      <= S_BURST;
          end
        end
        S_BURST: begin
          if (pmem_resp) begin
            r_line[int'(r_beat)*BEAT_W +: BEAT_W] <= pmem_rdata;
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) begin
              pmem_read   <= 1'b0;
              data_load   <= '1;
              tag_load    <= 1'b1;
              data_windex <= pmem_address[OFF_W +: IDX_W];
              tag_out     <= pmem_address[ADDR_W-1 -: TAG_W];
              r_state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          fill_done <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: table of fills with a 1-cycle-latency memory
// model, plus hand sequences for reset, mid-burst reset and back-to-back requests.
module tb_icache_line_fill;

  logic          clk;
  logic          rst_n;
  logic          missReq;
  logic [31:0]   missAddr;
  logic          busy;
  logic          fillDone;
  logic          pmemRead;
  logic [31:0]   pmemAddress;
  logic [63:0]   pmemRdata;
  logic          pmemResp;
  logic [31:0]   dataLoad;
  logic [2:0]    dataWindex;
  logic [255:0]  dataDatain;
  logic          tagLoad;
  logic [23:0]   tagOut;

  int nCompared = 0;
  int nMismatch = 0;

  typedef struct {
    logic [31:0]       addr;
    logic [3:0][63:0]  beats;
    int                stall;
    int                pulseCyc;
    logic [31:0]       pulseAddr;
    bit                extraResp;
    logic [31:0]       expAddr;
    logic [2:0]        expIdx;
    logic [23:0]       expTag;
    logic [255:0]      expLine;
    int                expDone;
  } fillVec_t;

  fillVec_t vecs[5];

  icache_line_fill dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_req     (missReq),
    .miss_addr    (missAddr),
    .busy         (busy),
    .fill_done    (fillDone),
    .pmem_read    (pmemRead),
    .pmem_address (pmemAddress),
    .pmem_rdata   (pmemRdata),
    .pmem_resp    (pmemResp),
    .data_load    (dataLoad),
    .data_windex  (dataWindex),
    .data_datain  (dataDatain),
    .tag_load     (tagLoad),
    .tag_out      (tagOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic fillVec_t mkVec(
    input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
    input logic [63:0] b2, input logic [63:0] b3, input int stall,
    input int pulseCyc, input logic [31:0] pulseAddr, input bit extraResp,
    input logic [31:0] expAddr, input logic [2:0] expIdx, input logic [23:0] expTag,
    input logic [255:0] expLine, input int expDone);
    fillVec_t v;
    v.addr      = addr;
    v.beats[0]  = b0;
    v.beats[1]  = b1;
    v.beats[2]  = b2;
    v.beats[3]  = b3;
    v.stall     = stall;
    v.pulseCyc  = pulseCyc;
    v.pulseAddr = pulseAddr;
    v.extraResp = extraResp;
    v.expAddr   = expAddr;
    v.expIdx    = expIdx;
    v.expTag    = expTag;
    v.expLine   = expLine;
    v.expDone   = expDone;
    return v;
  endfunction

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic resp, input logic [63:0] rdata);
    missReq   = req;
    missAddr  = addr;
    pmemResp  = resp;
    pmemRdata = rdata;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model answers one cycle after pmem_read is seen, then every stall+1 cycles.
  task automatic runFill(input fillVec_t v, input string tag);
    int            cyc = 0;
    int            j = 0;
    int            loads = 0;
    int            tagLoads = 0;
    int            doneCyc = 0;
    logic          addrBad = 1'b0;
    logic          tagWithLoad = 1'b0;
    logic [31:0]   seenLoad = '0;
    logic [2:0]    seenIdx = '0;
    logic [23:0]   seenTag = '0;
    logic [255:0]  seenLine = '0;
    logic          reqNow;
    @(negedge clk);
    applyStimulus(1'b1, v.addr, 1'b0, 64'h0);
    @(posedge clk);
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput({tag, "_read_up"}, pmemRead, 1);
      if (pmemRead && pmemAddress !== v.expAddr) addrBad = 1'b1;
      if (dataLoad != 0) begin
        loads++;
        seenLoad    = dataLoad;
        seenIdx     = dataWindex;
        seenTag     = tagOut;
        seenLine    = dataDatain;
        tagWithLoad = tagLoad;
      end
      if (tagLoad) tagLoads++;
      if (fillDone && doneCyc == 0) doneCyc = cyc;
      if (doneCyc != 0 && cyc > doneCyc) break;
      reqNow = (v.pulseCyc != 0 && cyc == v.pulseCyc);
      if (j < 4 && cyc == 2 + j * (v.stall + 1)) begin
        applyStimulus(reqNow, reqNow ? v.pulseAddr : v.addr, 1'b1, v.beats[j]);
        j++;
      end else if (j == 4 && v.extraResp) begin
        applyStimulus(reqNow, reqNow ? v.pulseAddr : v.addr, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
      end else begin
        applyStimulus(reqNow, reqNow ? v.pulseAddr : v.addr, 1'b0, 64'hDEAD_0000_0000_DEAD);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput({tag, "_addr_stable"}, addrBad, 0);
    checkOutput({tag, "_load_count"}, loads, 1);
    checkOutput({tag, "_tag_load_count"}, tagLoads, 1);
    checkOutput({tag, "_tag_with_load"}, tagWithLoad, 1);
    checkOutput({tag, "_load_mask"}, seenLoad, 32'hFFFF_FFFF);
    checkOutput({tag, "_windex"}, seenIdx, v.expIdx);
    checkOutput({tag, "_tag_out"}, seenTag, v.expTag);
    checkOutput({tag, "_line"}, seenLine, v.expLine);
    checkOutput({tag, "_done_cycle"}, doneCyc, v.expDone);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_read"}, pmemRead, 0);
    checkOutput({tag, "_line_held"}, dataDatain, v.expLine);
  endtask

  initial begin
    int loadsSeen;
    int cyc;
    int d1, d2, r1, r2;
    logic prevRead;
    logic idleBusy;
    logic [31:0] addr2;
    logic [2:0]  lastIdx;

    vecs[0] = mkVec(32'h0000_1A74, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, 32'h0, 1'b0,
                    32'h0000_1A60, 3'd3, 24'h00001A,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111, 7);
    vecs[1] = mkVec(32'h0000_1A74, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 2, 0, 32'h0, 1'b0,
                    32'h0000_1A60, 3'd3, 24'h00001A,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111, 13);
    vecs[2] = mkVec(32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 1, 0, 32'h0, 1'b1,
                    32'hDEAD_BEE0, 3'd7, 24'hDEADBE,
                    256'h5A5A5A5A5A5A5A5A_A5A5A5A5A5A5A5A5_FEDCBA9876543210_0123456789ABCDEF, 10);
    vecs[3] = mkVec(32'h0000_0080, 64'hCAFE_0000_0000_0000, 64'hCAFE_0001_0000_0001,
                    64'hCAFE_0002_0000_0002, 64'hCAFE_0003_0000_0003, 1, 3, 32'h0000_0040, 1'b0,
                    32'h0000_0080, 3'd4, 24'h000000,
                    256'hCAFE000300000003_CAFE000200000002_CAFE000100000001_CAFE000000000000, 10);
    vecs[4] = mkVec(32'hFFFF_FF1F, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 0, 0, 32'h0, 1'b0,
                    32'hFFFF_FF00, 3'd0, 24'hFFFFFF,
                    256'h0000000000000000_FFFFFFFFFFFFFFFF_7FFFFFFFFFFFFFFE_8000000000000001, 7);

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fill_done", fillDone, 0);
    checkOutput("rst_pmem_read", pmemRead, 0);
    checkOutput("rst_pmem_address", pmemAddress, 0);
    checkOutput("rst_data_load", dataLoad, 0);
    checkOutput("rst_data_windex", dataWindex, 0);
    checkOutput("rst_data_datain", dataDatain, 0);
    checkOutput("rst_tag_load", tagLoad, 0);
    checkOutput("rst_tag_out", tagOut, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput("idle_resp_busy", busy, 0);
    checkOutput("idle_resp_load", dataLoad, 0);
    checkOutput("idle_resp_buffer", dataDatain, 0);
    @(negedge clk);
    checkOutput("idle_resp_read", pmemRead, 0);

    for (int i = 0; i < 5; i++) begin
      runFill(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Reset after two beats must discard the partial line with no commit.
    loadsSeen = 0;
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_00E0, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("midrst_read_up", pmemRead, 1);
    applyStimulus(1'b0, 32'h0000_00E0, 1'b0, 64'h0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      if (dataLoad != 0 || tagLoad) loadsSeen++;
      applyStimulus(1'b0, 32'h0000_00E0, 1'b1, 64'h5757_5757_0000_0000 + 64'(c));
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_read_async", pmemRead, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_buffer", dataDatain, 0);
    repeat (2) begin
      @(negedge clk);
      if (dataLoad != 0 || tagLoad) loadsSeen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dataLoad != 0 || tagLoad) loadsSeen++;
    end
    checkOutput("midrst_no_commit", loadsSeen, 0);
    runFill(mkVec(32'h0000_0020, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                  64'h00FF_00FF_00FF_00FF, 64'hFF00_FF00_FF00_FF00, 0, 0, 32'h0, 1'b0,
                  32'h0000_0020, 3'd1, 24'h000000,
                  256'hFF00FF00FF00FF00_00FF00FF00FF00FF_F0F0F0F0F0F0F0F0_0F0F0F0F0F0F0F0F, 7),
            "postrst");
    repeat (2) @(negedge clk);

    // Held request: the second burst follows one IDLE cycle after DONE.
    cyc = 0; d1 = 0; d2 = 0; r1 = 0; r2 = 0;
    prevRead = 1'b0; idleBusy = 1'b1; addr2 = '0; lastIdx = '0;
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 64'h0);
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (fillDone) begin
        if (d1 == 0) d1 = cyc;
        else if (d2 == 0) d2 = cyc;
      end
      if (pmemRead && !prevRead) begin
        if (r1 == 0) r1 = cyc;
        else if (r2 == 0) begin
          r2 = cyc;
          addr2 = pmemAddress;
        end
      end
      if (d1 != 0 && cyc == d1 + 1) idleBusy = busy;
      if (dataLoad != 0) lastIdx = dataWindex;
      applyStimulus(r2 == 0, (d1 != 0) ? 32'h0000_4444 : 32'h0000_3000,
                    pmemRead && prevRead, 64'h0000_0000_0000_0000 + 64'(cyc));
      prevRead = pmemRead;
      if (d2 != 0) break;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput("b2b_first_done", d1, 7);
    checkOutput("b2b_idle_gap", idleBusy, 0);
    checkOutput("b2b_second_read", r2, 9);
    checkOutput("b2b_second_addr", addr2, 32'h0000_4440);
    checkOutput("b2b_second_done", d2, 15);
    checkOutput("b2b_second_idx", lastIdx, 3'd2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
